// File: rtl/ipr_write_arbiter.sv
// ipr_write_arbiter
// Round-robin arbiter that shares one outgoing IPR write port between
// NB_REQ upstream requesters (local cores plus forwarded router traffic).
// Only one transaction is outstanding at a time. The grant is held from the
// downstream request until its response returns.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   s_req_i/s_addr_i/s_wdata_i/s_we_i/s_be_i   upstream requests (slice i = requester i)
//   s_gnt_o, s_rvalid_o  per-requester grant / response valid (one-hot or zero)
//   s_rdata_o            response data, broadcast to all requesters
//   m_req_o/m_addr_o/m_wdata_o/m_we_o/m_be_o   downstream request
//   m_gnt_i, m_rvalid_i, m_rdata_i             downstream grant / response
//   err_o                one-cycle response-timeout pulse
//   dbg_state, dbg_rr_ptr  FSM state (0 IDLE, 1 REQ, 2 RESP) and round-robin pointer
//
// Build option
//   IPR_ARB_TIMEOUT_EN   enables the response watchdog (TIMEOUT_CYCLES).
//                        Without it RESP waits indefinitely and err_o is 0.
//
// Handshake (OBI-style, both sides): a requester raises req with a stable
// payload and holds both until it samples gnt high. The transfer is accepted
// in the cycle req && gnt. Exactly one rvalid pulse follows per accepted
// request. It may arrive in the same cycle as gnt or in any later cycle.
module ipr_write_arbiter #(
    parameter int NB_REQ         = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int IDX_W         = $clog2(NB_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NB_REQ-1:0]              s_req_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]   s_addr_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [NB_REQ-1:0]              s_we_i,
    input  logic [NB_REQ*BE_WIDTH-1:0]     s_be_i,
    output logic [NB_REQ-1:0]              s_gnt_o,
    output logic [NB_REQ-1:0]              s_rvalid_o,
    output logic [DATA_WIDTH-1:0]          s_rdata_o,
    output logic                           m_req_o,
    output logic [ADDR_WIDTH-1:0]          m_addr_o,
    output logic [DATA_WIDTH-1:0]          m_wdata_o,
    output logic                           m_we_o,
    output logic [BE_WIDTH-1:0]            m_be_o,
    input  logic                           m_gnt_i,
    input  logic                           m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]          m_rdata_i,
    output logic                           err_o,
    output logic [1:0]                     dbg_state,
    output logic [IDX_W-1:0]               dbg_rr_ptr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    if (NB_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ipr_write_arbiter: NB_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t             state, state_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]   winner, winner_d;
    logic [IDX_W-1:0]   pick;
    logic [NB_REQ-1:0]  req_rot;
    logic               found;
    int                 sum;
    logic               timeout;

    // Round-robin pick. Rotating the request vector right by rr_ptr puts
    // requester rr_ptr at bit 0. The first set bit is then the winner, and it
    // maps back to a requester index modulo NB_REQ.
    always_comb begin
        req_rot = NB_REQ'({s_req_i, s_req_i} >> rr_ptr);
        pick    = '0;
        found   = 1'b0;
        sum     = 0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                sum   = int'(rr_ptr) + i;
                if (sum >= NB_REQ) begin
                    sum = sum - NB_REQ;
                end
                pick  = IDX_W'(sum);
            end
        end
    end

    // Payload mux from the latched winner. It is always driven, so the data
    // outputs never float to X.
    always_comb begin
        m_addr_o  = '0;
        m_wdata_o = '0;
        m_we_o    = 1'b0;
        m_be_o    = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                m_addr_o  = s_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_wdata_o = s_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                m_we_o    = s_we_i[i];
                m_be_o    = s_be_i[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

`ifdef IPR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    // The counter is held at zero outside RESP, so it starts from zero on
    // every entry into RESP.
    always_ff @(posedge clk_i) begin
        if (rst_i || state != RESP) begin
            to_cnt <= '0;
        end else if (!m_rvalid_i && !timeout) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (state == RESP) && (to_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    assign err_o      = timeout;
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            rr_ptr <= '0;
            winner <= '0;
        end else begin
            state  <= state_d;
            rr_ptr <= rr_ptr_d;
            winner <= winner_d;
        end
    end

    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        winner_d   = winner;
        m_req_o    = 1'b0;
        s_gnt_o    = '0;
        s_rvalid_o = '0;
        s_rdata_o  = m_rdata_i;

        unique case (state)
            IDLE: begin
                if (|s_req_i) begin
                    winner_d = pick;
                    state_d  = REQ;
                end
            end
            REQ: begin
                m_req_o = s_req_i[winner];
                // A dropped request is an abort. Downstream sees no req, so a
                // grant in this cycle is not forwarded and the pointer keeps
                // its value.
                if (!s_req_i[winner]) begin
                    state_d = IDLE;
                end else if (m_gnt_i) begin
                    s_gnt_o[winner] = 1'b1;
                    rr_ptr_d = (winner == IDX_W'(NB_REQ - 1)) ? '0 : winner + 1'b1;
                    if (m_rvalid_i) begin
                        s_rvalid_o[winner] = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (timeout) begin
                    // A synthetic error response closes the transaction. The
                    // real response, if it ever arrives, lands in IDLE and is
                    // ignored.
                    s_rvalid_o[winner] = 1'b1;
                    s_rdata_o = DATA_WIDTH'(TIMEOUT_RDATA);
                    state_d   = IDLE;
                end else if (m_rvalid_i) begin
                    s_rvalid_o[winner] = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ipr_write_arbiter.sv
// tb_ipr_write_arbiter
// Bench for ipr_write_arbiter (NB_REQ=4, 32-bit data, TIMEOUT_CYCLES=8).
// Expected grants and responses go into queues when the stimulus is driven.
// A negedge monitor pops and compares them when the DUT asserts s_gnt_o or
// s_rvalid_o. Directed checks cover reset, latency, abort and reset-in-RESP.
// The watchdog scenario is built only with IPR_ARB_TIMEOUT_EN.
module tb_ipr_write_arbiter;
  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic clk;
  logic rst_i;
  logic [NB-1:0] s_req_i;
  logic [NB*AW-1:0] s_addr_i;
  logic [NB*DW-1:0] s_wdata_i;
  logic [NB-1:0] s_we_i;
  logic [NB*BW-1:0] s_be_i;
  logic [NB-1:0] s_gnt_o;
  logic [NB-1:0] s_rvalid_o;
  logic [DW-1:0] s_rdata_o;
  logic m_req_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o;
  logic m_we_o;
  logic [BW-1:0] m_be_o;
  logic m_gnt_i;
  logic m_rvalid_i;
  logic [DW-1:0] m_rdata_i;
  logic err_o;
  logic [1:0] dbg_state;
  logic [1:0] dbg_rr_ptr;

  int n_checks = 0;
  int n_fail = 0;

  // grant entry: {s_gnt, we, be, addr, wdata}; response entry: {s_rvalid, rdata}
  logic [72:0] exp_gnt_q[$];
  logic [35:0] exp_rv_q[$];
  logic [72:0] mon_g;
  logic [35:0] mon_r;

  ipr_write_arbiter #(
    .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_req_i(s_req_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i),
    .s_we_i(s_we_i), .s_be_i(s_be_i),
    .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
    .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_we_o(m_we_o), .m_be_o(m_be_o),
    .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .err_o(err_o), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    s_req_i = '0;
    m_gnt_i = 1'b0;
    m_rvalid_i = 1'b0;
    m_rdata_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic set_slice(input int i, input logic [31:0] a, input logic [31:0] d);
    s_addr_i[i*AW +: AW] = a;
    s_wdata_i[i*DW +: DW] = d;
    s_be_i[i*BW +: BW] = 4'hF;
    s_we_i[i] = 1'b1;
  endtask

  function automatic logic [NB-1:0] onehot(input int i);
    logic [NB-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic push_gnt(input int i, input logic [31:0] a, input logic [31:0] d);
    exp_gnt_q.push_back({onehot(i), 1'b1, 4'hF, a, d});
  endtask

  task automatic push_rv(input int i, input logic [31:0] d);
    exp_rv_q.push_back({onehot(i), d});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_i) begin
      if (s_gnt_o != '0) begin
        if (exp_gnt_q.size() == 0) begin
          check_eq("unexpected_gnt", {76'd0, s_gnt_o}, 80'd0);
        end else begin
          mon_g = exp_gnt_q.pop_front();
          check_eq("gnt_txn", {7'd0, s_gnt_o, m_we_o, m_be_o, m_addr_o, m_wdata_o}, {7'd0, mon_g});
        end
      end
      if (s_rvalid_o != '0) begin
        if (exp_rv_q.size() == 0) begin
          check_eq("unexpected_rvalid", {76'd0, s_rvalid_o}, 80'd0);
        end else begin
          mon_r = exp_rv_q.pop_front();
          check_eq("rvalid_txn", {44'd0, s_rvalid_o, s_rdata_o}, {44'd0, mon_r});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int ord[5] = '{0, 1, 2, 3, 0};
  int n_g;
  int t;
  logic prev_gnt;

  initial begin
    rst_i = 1'b1;
    s_req_i = '0;
    s_addr_i = '0;
    s_wdata_i = '0;
    s_we_i = '0;
    s_be_i = '0;
    m_gnt_i = 1'b0;
    m_rvalid_i = 1'b0;
    m_rdata_i = '0;
    do_reset();

    // reset state
    @(negedge clk);
    check_eq("rst_m_req", {79'd0, m_req_o}, 80'd0);
    check_eq("rst_s_gnt", {76'd0, s_gnt_o}, 80'd0);
    check_eq("rst_s_rvalid", {76'd0, s_rvalid_o}, 80'd0);
    check_eq("rst_err", {79'd0, err_o}, 80'd0);
    check_eq("rst_state", {78'd0, dbg_state}, {78'd0, ST_IDLE});
    check_eq("rst_rr_ptr", {78'd0, dbg_rr_ptr}, 80'd0);
    check_eq("rst_data_known",
             {76'd0, $isunknown(m_addr_o), $isunknown(m_wdata_o), $isunknown(m_be_o), $isunknown(s_rdata_o)},
             80'd0);

    // single requester 2: gnt at cycle 3, rvalid at cycle 5
    tick();
    set_slice(2, 32'h1000_0040, 32'hA5A5_0001);
    s_req_i = 4'b0100;
    @(negedge clk);
    check_eq("t1_c0_state", {78'd0, dbg_state}, {78'd0, ST_IDLE});
    check_eq("t1_c0_m_req", {79'd0, m_req_o}, 80'd0);
    tick();
    @(negedge clk);
    check_eq("t1_c1_state", {78'd0, dbg_state}, {78'd0, ST_REQ});
    check_eq("t1_c1_m_req", {79'd0, m_req_o}, 80'd1);
    check_eq("t1_c1_m_addr", {48'd0, m_addr_o}, {48'd0, 32'h1000_0040});
    tick();
    @(negedge clk);
    check_eq("t1_c2_m_addr", {48'd0, m_addr_o}, {48'd0, 32'h1000_0040});
    check_eq("t1_c2_s_gnt", {76'd0, s_gnt_o}, 80'd0);
    tick();
    m_gnt_i = 1'b1;
    push_gnt(2, 32'h1000_0040, 32'hA5A5_0001);
    @(negedge clk);
    check_eq("t1_c3_s_gnt", {76'd0, s_gnt_o}, {76'd0, 4'b0100});
    tick();
    m_gnt_i = 1'b0;
    s_req_i = '0;
    @(negedge clk);
    check_eq("t1_c4_state", {78'd0, dbg_state}, {78'd0, ST_RESP});
    check_eq("t1_c4_m_req", {79'd0, m_req_o}, 80'd0);
    tick();
    m_rvalid_i = 1'b1;
    m_rdata_i = 32'hC0DE_0005;
    push_rv(2, 32'hC0DE_0005);
    @(negedge clk);
    check_eq("t1_c5_s_rvalid", {76'd0, s_rvalid_o}, {76'd0, 4'b0100});
    tick();
    m_rvalid_i = 1'b0;
    @(negedge clk);
    check_eq("t1_c6_state", {78'd0, dbg_state}, {78'd0, ST_IDLE});
    check_eq("t1_rr_ptr", {78'd0, dbg_rr_ptr}, 80'd3);

    // abort: requester 1 wins from rr_ptr=3, then drops req before grant
    tick();
    set_slice(1, 32'h1000_0010, 32'h1111_0001);
    s_req_i = 4'b0010;
    @(negedge clk);
    tick();
    @(negedge clk);
    check_eq("ab_state_req", {78'd0, dbg_state}, {78'd0, ST_REQ});
    check_eq("ab_m_addr", {48'd0, m_addr_o}, {48'd0, 32'h1000_0010});
    tick();
    s_req_i = '0;
    @(negedge clk);
    check_eq("ab_no_gnt", {76'd0, s_gnt_o}, 80'd0);
    check_eq("ab_m_req", {79'd0, m_req_o}, 80'd0);
    tick();
    @(negedge clk);
    check_eq("ab_state_idle", {78'd0, dbg_state}, {78'd0, ST_IDLE});
    check_eq("ab_rr_ptr", {78'd0, dbg_rr_ptr}, 80'd3);
    // requester 2 is served next
    s_req_i = 4'b0100;
    @(negedge clk);
    tick();
    m_gnt_i = 1'b1;
    push_gnt(2, 32'h1000_0040, 32'hA5A5_0001);
    @(negedge clk);
    tick();
    m_gnt_i = 1'b0;
    s_req_i = '0;
    m_rvalid_i = 1'b1;
    m_rdata_i = 32'h0BAD_0002;
    push_rv(2, 32'h0BAD_0002);
    @(negedge clk);
    tick();
    m_rvalid_i = 1'b0;
    @(negedge clk);
    check_eq("ab_rr_after", {78'd0, dbg_rr_ptr}, 80'd3);

    // same-cycle gnt and rvalid, requester 1
    s_req_i = 4'b0010;
    @(negedge clk);
    tick();
    m_gnt_i = 1'b1;
    m_rvalid_i = 1'b1;
    m_rdata_i = 32'h0000_1234;
    push_gnt(1, 32'h1000_0010, 32'h1111_0001);
    push_rv(1, 32'h0000_1234);
    @(negedge clk);
    check_eq("sc_s_gnt", {76'd0, s_gnt_o}, {76'd0, 4'b0010});
    check_eq("sc_s_rvalid", {76'd0, s_rvalid_o}, {76'd0, 4'b0010});
    check_eq("sc_s_rdata", {48'd0, s_rdata_o}, {48'd0, 32'h0000_1234});
    tick();
    m_gnt_i = 1'b0;
    m_rvalid_i = 1'b0;
    s_req_i = '0;
    @(negedge clk);
    check_eq("sc_state_idle", {78'd0, dbg_state}, {78'd0, ST_IDLE});
    check_eq("sc_rr_ptr", {78'd0, dbg_rr_ptr}, 80'd2);

    // all four requesting, downstream always grants, rvalid one cycle later
    do_reset();
    for (int i = 0; i < NB; i++) begin
      set_slice(i, 32'h2000_0000 + 32'(i * 4), 32'h5A00_0000 + 32'(i));
    end
    for (int k = 0; k < 5; k++) begin
      push_gnt(ord[k], 32'h2000_0000 + 32'(ord[k] * 4), 32'h5A00_0000 + 32'(ord[k]));
    end
    s_req_i = 4'hF;
    m_gnt_i = 1'b1;
    prev_gnt = 1'b0;
    n_g = 0;
    t = 0;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) tick();
      m_rvalid_i = prev_gnt;
      if (prev_gnt && t < 5) begin
        m_rdata_i = 32'h7700_0000 + 32'(t);
        push_rv(ord[t], 32'h7700_0000 + 32'(t));
        t++;
      end
      @(negedge clk);
      prev_gnt = |s_gnt_o;
      if (prev_gnt) n_g++;
    end
    tick();
    s_req_i = '0;
    m_gnt_i = 1'b0;
    m_rvalid_i = 1'b0;
    @(negedge clk);
    check_eq("rr_grant_count", 80'(n_g), 80'd5);
    check_eq("rr_gnt_q_empty", 80'(exp_gnt_q.size()), 80'd0);
    check_eq("rr_rr_ptr", {78'd0, dbg_rr_ptr}, 80'd1);

    // reset asserted in RESP, then a late response arrives in IDLE
    set_slice(3, 32'h3000_000C, 32'h3333_0003);
    s_req_i = 4'b1000;
    @(negedge clk);
    tick();
    m_gnt_i = 1'b1;
    push_gnt(3, 32'h3000_000C, 32'h3333_0003);
    @(negedge clk);
    tick();
    m_gnt_i = 1'b0;
    s_req_i = '0;
    @(negedge clk);
    check_eq("rs_state_resp", {78'd0, dbg_state}, {78'd0, ST_RESP});
    tick();
    rst_i = 1'b1;
    @(negedge clk);
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check_eq("rs_outputs_zero", {72'd0, m_req_o, s_gnt_o, s_rvalid_o[2:0]}, 80'd0);
    check_eq("rs_rvalid3_err", {78'd0, s_rvalid_o[3], err_o}, 80'd0);
    check_eq("rs_state_idle", {78'd0, dbg_state}, {78'd0, ST_IDLE});
    check_eq("rs_rr_ptr", {78'd0, dbg_rr_ptr}, 80'd0);
    tick();
    m_rvalid_i = 1'b1;
    m_rdata_i = 32'h0000_FFFF;
    @(negedge clk);
    check_eq("rs_late_rvalid_dropped", {76'd0, s_rvalid_o}, 80'd0);
    tick();
    m_rvalid_i = 1'b0;
    @(negedge clk);
    check_eq("rs_still_idle", {78'd0, dbg_state}, {78'd0, ST_IDLE});

`ifdef IPR_ARB_TIMEOUT_EN
    // watchdog: rvalid held low, error response 8 cycles after RESP entry
    set_slice(0, 32'h4000_0000, 32'h4444_0000);
    s_req_i = 4'b0001;
    @(negedge clk);
    tick();
    m_gnt_i = 1'b1;
    push_gnt(0, 32'h4000_0000, 32'h4444_0000);
    @(negedge clk);
    tick();
    m_gnt_i = 1'b0;
    s_req_i = '0;
    @(negedge clk);
    check_eq("to_entry_state", {78'd0, dbg_state}, {78'd0, ST_RESP});
    check_eq("to_entry_err", {79'd0, err_o}, 80'd0);
    for (int k = 1; k < TO; k++) begin
      tick();
      @(negedge clk);
      check_eq("to_wait_err", {79'd0, err_o}, 80'd0);
    end
    tick();
    push_rv(0, 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("to_err", {79'd0, err_o}, 80'd1);
    check_eq("to_s_rvalid", {76'd0, s_rvalid_o}, 80'd1);
    check_eq("to_s_rdata", {48'd0, s_rdata_o}, {48'd0, 32'hDEAD_BEEF});
    tick();
    m_rvalid_i = 1'b1;
    @(negedge clk);
    check_eq("to_stale_dropped", {75'd0, s_rvalid_o, err_o}, 80'd0);
    check_eq("to_state_idle", {78'd0, dbg_state}, {78'd0, ST_IDLE});
    tick();
    m_rvalid_i = 1'b0;
`endif

    tick();
    @(negedge clk);
    check_eq("final_gnt_q_empty", 80'(exp_gnt_q.size()), 80'd0);
    check_eq("final_rv_q_empty", 80'(exp_rv_q.size()), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
